keccak_squeeze: RTL and testbench
=================================

KECCAK_SQUEEZE -- requirements
Module: keccak_squeeze

Interface
REQ-001 Parameter BW_DATA, default 1600, Keccak state width in bits (5x5 lanes of 64 bits).
REQ-002 Parameter BW_WORD, default 64, output word width (one lane).
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rstn  input  1  asynchronous active-low reset.
REQ-005 i_start  input  1  one-cycle squeeze start strobe; honoured only in IDLE.
REQ-006 i_mode  input  1  rate select sampled with i_start: 0 = SHAKE128 (21 lanes), 1 = SHAKE256 (17 lanes).
REQ-007 i_nwords  input  16  number of 64-bit output words requested, sampled with i_start.
REQ-008 i_state  input  BW_DATA  permuted state from keccakf1600.
REQ-009 i_valid  input  1  i_state valid strobe from keccakf1600.
REQ-010 o_perm_state  output  BW_DATA  state returned to keccakf1600 for the next permutation.
REQ-011 o_perm_valid  output  1  one-cycle permutation request strobe.
REQ-012 o_word  output  BW_WORD  current squeezed lane.
REQ-013 o_word_valid  output  1  o_word holds a valid word.
REQ-014 i_word_ready  input  1  downstream accepts o_word when high with o_word_valid.
REQ-015 o_busy  output  1  high in every state except IDLE.
REQ-016 o_done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-017 Lane i = x+5y occupies bits [BW_DATA-1-64*i -: 64] of i_state and o_perm_state; squeeze order is lane 0, 1, ..., rate-1.
REQ-018 States: IDLE, WAIT_STATE, OUT, PERM; one-hot or binary encoding is free.
REQ-019 IDLE: i_start with i_nwords!=0 latches mode and count, clears lane index, enters WAIT_STATE; i_start with i_nwords==0 produces o_done the next cycle and stays IDLE.
REQ-020 IDLE: i_valid is ignored; i_start outside IDLE is ignored.
REQ-021 WAIT_STATE: i_valid loads i_state into a 1600-bit buffer, enters OUT the next cycle; i_start ignored.
REQ-022 OUT: o_word_valid=1, o_word=buffer lane[index]; o_word remains stable while o_word_valid=1 and i_word_ready=0.
REQ-023 OUT: a transfer (o_word_valid & i_word_ready) decrements remaining count and increments index.
REQ-024 Transfer with remaining==1: o_done pulses the following cycle, return to IDLE; no permutation requested.
REQ-025 Transfer with remaining>1 and index==rate-1: index wraps to 0, enter PERM.
REQ-026 PERM: o_perm_valid=1 for exactly one cycle with o_perm_state=buffer, then WAIT_STATE.
REQ-027 Latency: i_valid to first o_word_valid = 1 cycle; last transfer to o_done = 1 cycle; rate-exhaustion transfer to o_perm_valid = 1 cycle.
REQ-028 Sustained throughput: one word per cycle while i_word_ready=1 within a block.
REQ-029 i_valid arriving in OUT or PERM is ignored and does not corrupt the buffer.
REQ-030 o_word_valid=0 in IDLE, WAIT_STATE and PERM; o_perm_state is don't-care when o_perm_valid=0.
REQ-031 o_busy deasserts in the same cycle o_done pulses.

Reset
REQ-032 Reset asserted drives state to IDLE, o_perm_valid, o_word_valid, o_busy, o_done to 0, index and count to 0 immediately, independent of i_clk.
REQ-033 Buffer contents need not be reset; o_word is don't-care while o_word_valid=0.
REQ-034 Reset mid-operation aborts the squeeze without o_done; the first cycle after release is IDLE and accepts i_start.

Verification
REQ-035 Mode 0, nwords=3, i_state lanes = lane index, ready=1 -> o_word 0,1,2 on consecutive cycles, o_done 1 cycle after word 2, no o_perm_valid.
REQ-036 Mode 0, nwords=22 -> words lane 0..20, single o_perm_valid pulse carrying buffered state, after new i_valid word 21 = new lane 0, then o_done.
REQ-037 Mode 1, nwords=17 -> exactly 17 words ending at lane 16, no o_perm_valid; nwords=18 -> one o_perm_valid after lane 16.
REQ-038 Random i_word_ready backpressure, nwords=5 -> o_word stable while stalled, sequence 0..4 unchanged, o_done once.
REQ-039 i_start with nwords=0 -> o_done next cycle, o_busy stays 0; spurious i_valid in IDLE and i_start during OUT -> no effect.
REQ-040 i_rstn low during OUT at word 2 of 10 -> outputs 0 asynchronously, no o_done; new i_start after release squeezes normally from lane 0.

Source files
------------

// File: rtl/keccak_squeeze.sv
// Keccak squeeze engine: streams rate lanes of a permuted state as 64-bit words,
// requesting further permutations from keccakf1600 until the word count is met.
module keccak_squeeze #(
  parameter int BW_DATA = 1600,
  parameter int BW_WORD = 64
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic [15:0]        i_nwords,
  input  logic [BW_DATA-1:0] i_state,
  input  logic               i_valid,
  output logic [BW_DATA-1:0] o_perm_state,
  output logic               o_perm_valid,
  output logic [BW_WORD-1:0] o_word,
  output logic               o_word_valid,
  input  logic               i_word_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NLANE  = BW_DATA / BW_WORD;
  localparam int BW_IDX = $clog2(NLANE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_PERM = 2'd3;

  logic [1:0]         r_state;
  logic               r_mode;
  logic [15:0]        r_cnt;
  logic [BW_IDX-1:0]  r_idx;
  logic               r_done;
  logic [BW_DATA-1:0] r_buf;

  logic [BW_WORD-1:0] w_lane [NLANE];
  logic [BW_IDX-1:0]  w_last_idx;
  logic               w_xfer;

  // Lane 0 sits in the most significant 64 bits
  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    assign w_lane[g] = r_buf[BW_DATA-1-BW_WORD*g -: BW_WORD];
  end

  assign w_last_idx = r_mode ? BW_IDX'(16) : BW_IDX'(20);
  assign w_xfer     = (r_state == S_OUT) && i_word_ready;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_nwords == 16'd0) begin
              r_done <= 1'b1;
            end else begin
              r_mode  <= i_mode;
              r_cnt   <= i_nwords;
              r_idx   <= '0;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (i_valid) r_state <= S_OUT;
        end
        S_OUT: begin
          if (w_xfer) begin
            r_cnt <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else if (r_idx == w_last_idx) begin
              r_idx   <= '0;
              r_state <= S_PERM;
            end else begin
              r_idx <= r_idx + BW_IDX'(1);
            end
          end
        end
        S_PERM: r_state <= S_WAIT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data buffer carries no reset; it is only read in OUT and PERM
  always_ff @(posedge i_clk) begin
    if (r_state == S_WAIT && i_valid) r_buf <= i_state;
  end

  assign o_word       = w_lane[r_idx];
  assign o_word_valid = (r_state == S_OUT);
  assign o_perm_valid = (r_state == S_PERM);
  assign o_perm_state = r_buf;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;

endmodule

// File: tb/tb_keccak_squeeze.sv
// Directed bench for keccak_squeeze with a small keccakf responder model.
module tb_keccak_squeeze;

  logic          clk = 0;
  logic          rst_n;
  logic          i_start, i_mode, i_valid, i_word_ready;
  logic [15:0]   i_nwords;
  logic [1599:0] i_state;
  logic [1599:0] o_perm_state;
  logic          o_perm_valid, o_word_valid, o_busy, o_done;
  logic [63:0]   o_word;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] got[$];
  int g_nperm, g_ndone, g_stall_bad, g_perm_bad, g_busy_bad, g_perm_at;
  int g_timeout;

  keccak_squeeze dut (
    .i_clk       (clk),
    .i_rstn      (rst_n),
    .i_start     (i_start),
    .i_mode      (i_mode),
    .i_nwords    (i_nwords),
    .i_state     (i_state),
    .i_valid     (i_valid),
    .o_perm_state(o_perm_state),
    .o_perm_valid(o_perm_valid),
    .o_word      (o_word),
    .o_word_valid(o_word_valid),
    .i_word_ready(i_word_ready),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  // Generation g state: lane i holds g*256 + i
  function automatic logic [1599:0] mk_state(input int g);
    logic [1599:0] s;
    s = '0;
    for (int i = 0; i < 25; i++) s[1599-64*i -: 64] = 64'(g * 256 + i);
    return s;
  endfunction

  // Drives one squeeze and plays keccakf; results are left in globals
  task automatic run_squeeze(input bit mode, input logic [15:0] nw,
                             input bit rnd, input bit noise);
    int gen, vcnt, tail;
    bit hold, injected;
    logic [63:0] hw;
    got.delete();
    g_nperm = 0; g_ndone = 0; g_stall_bad = 0; g_perm_bad = 0;
    g_busy_bad = 0; g_perm_at = -1; g_timeout = 0;
    gen = 0; vcnt = -1; hold = 0; injected = 0; tail = -1; hw = '0;
    @(negedge clk);
    i_start = 1; i_mode = mode; i_nwords = nw; i_word_ready = 1;
    @(negedge clk);
    i_start = 0; i_valid = 1; i_state = mk_state(0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      i_valid = 0; i_start = 0;
      if (hold && (!o_word_valid || o_word !== hw)) g_stall_bad++;
      if (o_perm_valid) begin
        g_nperm++;
        if (g_perm_at < 0) g_perm_at = got.size();
        if (o_perm_state !== mk_state(gen)) g_perm_bad++;
        gen++;
        vcnt = 2;
      end
      if (vcnt > 0) vcnt--;
      else if (vcnt == 0) begin
        i_valid = 1; i_state = mk_state(gen); vcnt = -1;
      end
      if (o_done) begin
        g_ndone++;
        if (o_busy) g_busy_bad++;
        if (tail < 0) tail = 4;
      end
      if (noise && o_word_valid && !injected) begin
        i_start = 1; i_nwords = 16'd1;
        i_valid = 1; i_state = mk_state(99);
        injected = 1;
      end
      i_word_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_word_valid && i_word_ready) begin
        got.push_back(o_word); hold = 0;
      end else if (o_word_valid) begin
        hold = 1; hw = o_word;
      end else hold = 0;
      if (tail > 0) begin
        tail--;
        if (tail == 0) break;
      end
    end
    if (tail != 0) g_timeout = 1;
    i_valid = 0; i_start = 0; i_word_ready = 1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    n_cmp++;
    if (o_word_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wvalid: got %b want 0", o_word_valid); end
    n_cmp++;
    if (o_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", o_done); end
    n_cmp++;
    if (o_perm_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pvalid: got %b want 0", o_perm_valid); end
  endtask

  task automatic test_basic();
    int perm_seen;
    perm_seen = 0;
    @(negedge clk);
    i_start = 1; i_mode = 0; i_nwords = 16'd3; i_word_ready = 1;
    @(negedge clk);
    i_start = 0;
    n_cmp++;
    if (o_busy !== 1'b1 || o_word_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_wait: busy %b wvalid %b want 1 0", o_busy, o_word_valid);
    end
    i_valid = 1; i_state = mk_state(0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_valid = 0;
      if (o_perm_valid) perm_seen++;
      n_cmp++;
      if (o_word_valid !== 1'b1 || o_word !== 64'(k)) begin
        n_bad++; $display("FAIL basic_word%0d: valid %b word %0h want 1 %0h", k, o_word_valid, o_word, k);
      end
    end
    @(negedge clk);
    if (o_perm_valid) perm_seen++;
    n_cmp++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_word_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_done: done %b busy %b wvalid %b want 1 0 0", o_done, o_busy, o_word_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (o_done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", o_done); end
    n_cmp++;
    if (perm_seen !== 0) begin n_bad++; $display("FAIL basic_noperm: got %0d want 0", perm_seen); end
  endtask

  task automatic test_perm128();
    int bad;
    run_squeeze(0, 16'd22, 0, 0);
    n_cmp++;
    if (got.size() !== 22) begin n_bad++; $display("FAIL p128_count: got %0d want 22", got.size()); end
    bad = 0;
    foreach (got[k]) if (got[k] !== 64'((k / 21) * 256 + k % 21)) bad++;
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL p128_words: got %0d wrong want 0", bad); end
    n_cmp++;
    if (g_nperm !== 1 || g_perm_at !== 21) begin
      n_bad++; $display("FAIL p128_perm: got %0d at %0d want 1 at 21", g_nperm, g_perm_at);
    end
    n_cmp++;
    if (g_perm_bad !== 0) begin n_bad++; $display("FAIL p128_pstate: got %0d bad want 0", g_perm_bad); end
    n_cmp++;
    if (g_ndone !== 1 || g_timeout !== 0) begin
      n_bad++; $display("FAIL p128_done: got %0d timeout %0d want 1 0", g_ndone, g_timeout);
    end
  endtask

  task automatic test_mode256();
    int bad;
    run_squeeze(1, 16'd17, 0, 0);
    bad = 0;
    foreach (got[k]) if (got[k] !== 64'(k)) bad++;
    n_cmp++;
    if (got.size() !== 17 || bad !== 0) begin
      n_bad++; $display("FAIL m256_17: got %0d words %0d wrong want 17 0", got.size(), bad);
    end
    n_cmp++;
    if (g_nperm !== 0 || g_ndone !== 1 || g_timeout !== 0) begin
      n_bad++; $display("FAIL m256_17_ctl: perm %0d done %0d to %0d want 0 1 0", g_nperm, g_ndone, g_timeout);
    end
    run_squeeze(1, 16'd18, 0, 0);
    bad = 0;
    foreach (got[k]) if (got[k] !== 64'((k / 17) * 256 + k % 17)) bad++;
    n_cmp++;
    if (got.size() !== 18 || bad !== 0) begin
      n_bad++; $display("FAIL m256_18: got %0d words %0d wrong want 18 0", got.size(), bad);
    end
    n_cmp++;
    if (g_nperm !== 1 || g_perm_at !== 17 || g_perm_bad !== 0) begin
      n_bad++; $display("FAIL m256_18_perm: got %0d at %0d bad %0d want 1 17 0", g_nperm, g_perm_at, g_perm_bad);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    run_squeeze(0, 16'd5, 1, 0);
    bad = 0;
    foreach (got[k]) if (got[k] !== 64'(k)) bad++;
    n_cmp++;
    if (got.size() !== 5 || bad !== 0) begin
      n_bad++; $display("FAIL bp_words: got %0d words %0d wrong want 5 0", got.size(), bad);
    end
    n_cmp++;
    if (g_stall_bad !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable want 0", g_stall_bad); end
    n_cmp++;
    if (g_ndone !== 1 || g_busy_bad !== 0 || g_timeout !== 0) begin
      n_bad++; $display("FAIL bp_done: got %0d busy %0d to %0d want 1 0 0", g_ndone, g_busy_bad, g_timeout);
    end
  endtask

  task automatic test_zero_and_spurious();
    int bad;
    @(negedge clk);
    i_start = 1; i_mode = 0; i_nwords = 16'd0;
    @(negedge clk);
    i_start = 0;
    n_cmp++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      n_bad++; $display("FAIL zero_done: done %b busy %b want 1 0", o_done, o_busy);
    end
    i_valid = 1; i_state = mk_state(7);
    @(negedge clk);
    i_valid = 0;
    n_cmp++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_word_valid !== 1'b0) begin
      n_bad++; $display("FAIL idle_valid: done %b busy %b wvalid %b want 0 0 0", o_done, o_busy, o_word_valid);
    end
    run_squeeze(0, 16'd4, 0, 1);
    bad = 0;
    foreach (got[k]) if (got[k] !== 64'(k)) bad++;
    n_cmp++;
    if (got.size() !== 4 || bad !== 0 || g_ndone !== 1 || g_nperm !== 0) begin
      n_bad++; $display("FAIL out_noise: got %0d words %0d wrong done %0d perm %0d want 4 0 1 0",
                        got.size(), bad, g_ndone, g_nperm);
    end
  endtask

  task automatic test_reset_mid();
    int bad, dn;
    @(negedge clk);
    i_start = 1; i_mode = 0; i_nwords = 16'd10; i_word_ready = 1;
    @(negedge clk);
    i_start = 0; i_valid = 1; i_state = mk_state(0);
    @(negedge clk);
    i_valid = 0;
    @(negedge clk);
    @(negedge clk);
    i_word_ready = 0;
    n_cmp++;
    if (o_word_valid !== 1'b1 || o_word !== 64'd2) begin
      n_bad++; $display("FAIL rmid_word2: valid %b word %0h want 1 2", o_word_valid, o_word);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (o_word_valid !== 1'b0 || o_busy !== 1'b0 || o_perm_valid !== 1'b0 || o_done !== 1'b0) begin
      n_bad++; $display("FAIL rmid_async: wv %b busy %b pv %b done %b want 0 0 0 0",
                        o_word_valid, o_busy, o_perm_valid, o_done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1; i_word_ready = 1;
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (o_done || o_busy) dn++;
    end
    n_cmp++;
    if (dn !== 0) begin n_bad++; $display("FAIL rmid_quiet: got %0d active cycles want 0", dn); end
    run_squeeze(0, 16'd3, 0, 0);
    bad = 0;
    foreach (got[k]) if (got[k] !== 64'(k)) bad++;
    n_cmp++;
    if (got.size() !== 3 || bad !== 0 || g_ndone !== 1) begin
      n_bad++; $display("FAIL rmid_restart: got %0d words %0d wrong done %0d want 3 0 1",
                        got.size(), bad, g_ndone);
    end
  endtask

  initial begin
    rst_n = 0; i_start = 0; i_mode = 0; i_nwords = '0;
    i_state = '0; i_valid = 0; i_word_ready = 1;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1;
    test_basic();
    test_perm128();
    test_mode256();
    test_backpressure();
    test_zero_and_spurious();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
